// File: rtl/uart_pkg.sv
// Shared types for the console UART transmitter: FSM state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-strobe and status bundle between the data RAM's UART tap (master) and uart_tx (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic [FRAME_DATA_BITS-1:0] i_write_uart;
  logic                       i_write_uart_en;
  logic                       o_tx;
  logic                       o_busy;
  logic                       o_full;
  logic                       o_overflow;

  modport master (
    output i_write_uart, i_write_uart_en,
    input  o_tx, o_busy, o_full, o_overflow
  );

  modport slave (
    input  i_write_uart, i_write_uart_en,
    output o_tx, o_busy, o_full, o_overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for uart_tx; push and pop may coincide at any fill level,
// including full, and a pop on empty is ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rd_ptr];

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// Console UART transmitter: buffers byte strobes and sends them LSB-first as 8N1 frames.
// UART_TX_PARITY_EN adds an even-parity bit (8E1); UART_TX_SIM_ECHO echoes bytes in simulation.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

  uart_tx_state_t             state_q;
  logic [BW-1:0]              baud_q;
  logic [2:0]                 bit_idx_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic                       tx_q;
  logic                       ovf_q;
`ifdef UART_TX_PARITY_EN
  logic                       par_q;
`endif

  logic [FRAME_DATA_BITS-1:0] fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CW-1:0]              fifo_count;
  logic                       baud_wrap;
  logic                       pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.i_write_uart_en),
    .din   (bus.i_write_uart),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_wrap = (baud_q == BAUD_LAST);
  // Popping at the end of STOP chains frames with no idle cycle in between.
  assign pop = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_wrap));

  assign bus.o_tx       = tx_q;
  assign bus.o_busy     = (state_q != IDLE) || (fifo_count != '0);
  assign bus.o_full     = fifo_full;
  assign bus.o_overflow = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      if (state_q == IDLE || baud_wrap) baud_q <= '0;
      else                              baud_q <= baud_q + 1'b1;

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_wrap) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_wrap) begin
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Data path: loaded at pop, no reset needed since it is only read inside a frame.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= fifo_dout;
`ifdef UART_TX_PARITY_EN
      par_q   <= even_parity(fifo_dout);
`endif
    end else if (state_q == DATA && baud_wrap) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (bus.i_write_uart_en && fifo_full && !pop) ovf_q <= 1'b1;
  end

`ifdef UART_TX_SIM_ECHO
  always @(posedge clk) begin
    if (pop) $write("%c", fifo_dout);
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; frames decoded at mid-bit.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [7:0] rx_byte  [8];
  logic       rx_start [8];
  logic       rx_stop  [8];
`ifdef UART_TX_PARITY_EN
  logic       rx_par   [8];
`endif
  logic       rx_timeout;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic do_reset();
    bus.i_write_uart_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a start bit, then samples n contiguous frames one cycle into each bit.
  task automatic recv(input int n);
    int  i;
    logic v;
    rx_timeout = 1'b0;
    i = 0;
    while (bus.o_tx !== 1'b0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (bus.o_tx !== 1'b0) begin
      rx_timeout = 1'b1;
      return;
    end
    for (int f = 0; f < n; f++)
      for (int b = 0; b < FB; b++)
        for (int c = 0; c < CPB; c++) begin
          if (f != 0 || b != 0 || c != 0) @(negedge clk);
          if (c == 1) begin
            v = bus.o_tx;
            if (b == 0) rx_start[f] = v;
            else if (b <= 8) rx_byte[f][b-1] = v;
            else if (b == FB - 1) rx_stop[f] = v;
`ifdef UART_TX_PARITY_EN
            else rx_par[f] = v;
`endif
          end
        end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_write_uart    = 8'h00;
    bus.i_write_uart_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.o_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.o_tx); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.o_full); else n_pass++;
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.o_overflow); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [FB-1:0] exp;
`ifdef UART_TX_PARITY_EN
    exp = 11'b10010000010;
`else
    exp = 10'b1010000010;
`endif
    bus.i_write_uart    = 8'h41;
    bus.i_write_uart_en = 1'b1;
    @(negedge clk);
    bus.i_write_uart_en = 1'b0;
    n_checks++; if (bus.o_tx !== 1'b1) $display("FAIL single_pre_start: got %b want 1", bus.o_tx); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL single_busy_queued: got %b want 1", bus.o_busy); else n_pass++;
    for (int b = 0; b < FB; b++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        n_checks++;
        if (bus.o_tx !== exp[b]) $display("FAIL single_bit%0d_cyc%0d: got %b want %b", b, c, bus.o_tx, exp[b]);
        else n_pass++;
      end
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL single_busy_stop: got %b want 1", bus.o_busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_tx !== 1'b1) $display("FAIL single_idle_tx: got %b want 1", bus.o_tx); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [3];
    v[0] = 8'h55; v[1] = 8'hAA; v[2] = 8'h0F;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          bus.i_write_uart    = v[i];
          bus.i_write_uart_en = 1'b1;
          @(negedge clk);
        end
        bus.i_write_uart_en = 1'b0;
      end
      recv(3);
    join
    n_checks++; if (rx_timeout !== 1'b0) $display("FAIL b2b_timeout: got %b want 0", rx_timeout); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      n_checks++; if (rx_start[f] !== 1'b0) $display("FAIL b2b_start%0d: got %b want 0", f, rx_start[f]); else n_pass++;
      n_checks++; if (rx_byte[f] !== v[f]) $display("FAIL b2b_byte%0d: got %h want %h", f, rx_byte[f], v[f]); else n_pass++;
      n_checks++; if (rx_stop[f] !== 1'b1) $display("FAIL b2b_stop%0d: got %b want 1", f, rx_stop[f]); else n_pass++;
    end
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", bus.o_overflow); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus.i_write_uart    = 8'(i);
          bus.i_write_uart_en = 1'b1;
          @(negedge clk);
          if (i == 4) begin
            n_checks++; if (bus.o_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", bus.o_full); else n_pass++;
            n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.o_overflow); else n_pass++;
          end
          if (i == 5) begin
            n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.o_overflow); else n_pass++;
          end
        end
        bus.i_write_uart_en = 1'b0;
      end
      recv(5);
    join
    n_checks++; if (rx_timeout !== 1'b0) $display("FAIL ovf_timeout: got %b want 0", rx_timeout); else n_pass++;
    for (int f = 0; f < 5; f++) begin
      n_checks++;
      if (rx_byte[f] !== 8'(f) || rx_start[f] !== 1'b0 || rx_stop[f] !== 1'b1)
        $display("FAIL ovf_frame%0d: got byte %h start %b stop %b want byte %h start 0 stop 1",
                 f, rx_byte[f], rx_start[f], rx_stop[f], 8'(f));
      else n_pass++;
    end
    repeat (6) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL ovf_idle_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_tx !== 1'b1) $display("FAIL ovf_idle_tx: got %b want 1", bus.o_tx); else n_pass++;
    n_checks++; if (bus.o_full !== 1'b0) $display("FAIL ovf_idle_full: got %b want 0", bus.o_full); else n_pass++;
    n_checks++; if (bus.o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.i_write_uart    = 8'hA0 + 8'(i);
      bus.i_write_uart_en = 1'b1;
      @(negedge clk);
    end
    bus.i_write_uart_en = 1'b0;
    // Align the next strobe with the edge that ends the first frame's stop bit.
    repeat (FB * CPB - 4) @(negedge clk);
    n_checks++; if (bus.o_full !== 1'b1) $display("FAIL fpp_full_before: got %b want 1", bus.o_full); else n_pass++;
    bus.i_write_uart    = 8'hA5;
    bus.i_write_uart_en = 1'b1;
    @(negedge clk);
    bus.i_write_uart_en = 1'b0;
    n_checks++; if (bus.o_full !== 1'b1) $display("FAIL fpp_full_after: got %b want 1", bus.o_full); else n_pass++;
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL fpp_ovf: got %b want 0", bus.o_overflow); else n_pass++;
    n_checks++; if (bus.o_tx !== 1'b0) $display("FAIL fpp_next_start: got %b want 0", bus.o_tx); else n_pass++;
    recv(5);
    n_checks++; if (rx_timeout !== 1'b0) $display("FAIL fpp_timeout: got %b want 0", rx_timeout); else n_pass++;
    for (int f = 0; f < 5; f++) begin
      n_checks++;
      if (rx_byte[f] !== 8'hA1 + 8'(f) || rx_start[f] !== 1'b0 || rx_stop[f] !== 1'b1)
        $display("FAIL fpp_frame%0d: got byte %h start %b stop %b want byte %h start 0 stop 1",
                 f, rx_byte[f], rx_start[f], rx_stop[f], 8'hA1 + 8'(f));
      else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL fpp_idle_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_overflow !== 1'b0) $display("FAIL fpp_ovf_end: got %b want 0", bus.o_overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic bad;
    do_reset();
    bus.i_write_uart    = 8'h3C;
    bus.i_write_uart_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.i_write_uart_en = 1'b0;
    // Now one cycle into START; move to data bit 6 (a zero) of 0x3C.
    repeat (28) @(negedge clk);
    n_checks++; if (bus.o_tx !== 1'b0) $display("FAIL rst_mid_pre_tx: got %b want 0", bus.o_tx); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL rst_mid_pre_busy: got %b want 1", bus.o_busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_tx !== 1'b1) $display("FAIL rst_mid_tx: got %b want 1", bus.o_tx); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_full !== 1'b0) $display("FAIL rst_mid_full: got %b want 0", bus.o_full); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL rst_mid_quiet: got activity %b want 0", bad); else n_pass++;
    fork
      begin
        bus.i_write_uart    = 8'h3C;
        bus.i_write_uart_en = 1'b1;
        @(negedge clk);
        bus.i_write_uart_en = 1'b0;
      end
      recv(1);
    join
    n_checks++; if (rx_timeout !== 1'b0) $display("FAIL rst_mid_timeout: got %b want 0", rx_timeout); else n_pass++;
    n_checks++;
    if (rx_byte[0] !== 8'h3C || rx_start[0] !== 1'b0 || rx_stop[0] !== 1'b1)
      $display("FAIL rst_mid_frame: got byte %h start %b stop %b want byte 3c start 0 stop 1",
               rx_byte[0], rx_start[0], rx_stop[0]);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_parity();
    logic [7:0] v [2];
    logic       p [2];
    v[0] = 8'h07; p[0] = 1'b1;
    v[1] = 8'h03; p[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fork
        begin
          bus.i_write_uart    = v[k];
          bus.i_write_uart_en = 1'b1;
          @(negedge clk);
          bus.i_write_uart_en = 1'b0;
        end
        recv(1);
      join
      n_checks++; if (rx_timeout !== 1'b0) $display("FAIL par%0d_timeout: got %b want 0", k, rx_timeout); else n_pass++;
      n_checks++; if (rx_byte[0] !== v[k]) $display("FAIL par%0d_byte: got %h want %h", k, rx_byte[0], v[k]); else n_pass++;
      n_checks++; if (rx_stop[0] !== 1'b1) $display("FAIL par%0d_stop: got %b want 1", k, rx_stop[0]); else n_pass++;
`ifdef UART_TX_PARITY_EN
      n_checks++; if (rx_par[0] !== p[k]) $display("FAIL par%0d_bit: got %b want %b", k, rx_par[0], p[k]); else n_pass++;
`else
      if (p[k] === 1'bx) $display("unexpected parity table entry");
`endif
      repeat (3) @(negedge clk);
      n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL par%0d_idle: got %b want 0", k, bus.o_busy); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_reset_mid_frame();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
